hours_counter_cfg: RTL and testbench
====================================

Name: hours_counter_cfg

Overview:
Parametrised BCD hours counter for the digital-clock datapath. It is the successor to the fixed 24-hour counter. It counts 1-hour ticks from the minutes stage and supports a runtime 12/24-hour display mode with an AM/PM flag. It also provides validated parallel load, up/down adjust for time setting, and a registered day-carry pulse for a downstream day/date counter.

Parameters:
RESET_HOUR, 0, internal hour (0..23, 24h encoding) taken on reset; values >23 are illegal (elaboration error)
ENABLE_12H, 1, when 0 the mode_12h input is ignored and the block is 24h-only

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  one-cycle hour tick from the minutes counter carry
mode_12h  input  1  1 = 12-hour display, 0 = 24-hour display
adj_up  input  1  set-mode increment, one hour per asserted cycle
adj_down  input  1  set-mode decrement, one hour per asserted cycle
load  input  1  parallel load strobe
load_tens  input  4  BCD tens to load, interpreted in the current mode
load_units  input  4  BCD units to load
load_pm  input  1  PM flag for the load; used only in 12h mode
tens  output  4  BCD tens of the displayed hour
units  output  4  BCD units of the displayed hour
pm  output  1  1 when internal hour >= 12, valid in both modes
day_carry  output  1  one-cycle pulse on a tick-driven wrap 23->0
load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- State: internal binary hour register h, 5 bits, range 0..23. All outputs are registered and derived from next-h and the current mode on the same edge. A state change is therefore visible on the outputs the cycle after the causing edge, with no extra latency.
- Reset (async): h = RESET_HOUR. tens/units = 24h BCD of RESET_HOUR. pm = (RESET_HOUR >= 12). day_carry = 0, load_err = 0.
- 12h display is applied from the first clock edge after reset release.
- Effective mode: m12 = mode_12h & ENABLE_12H.
- Display encoding:
  - 24h: tens/units = BCD(h), 00..23.
  - 12h: d = 12 if h%12 == 0, else h%12; tens/units = BCD(d), 01..12.
  - pm = (h >= 12) in both modes.
- Mode change: h is unchanged; the display re-encodes on the next edge. For example, h = 0 shows 00 in 24h and 12 AM in 12h.
- Priority per cycle: load > adjust > enable. Lower-priority inputs in the same cycle are ignored, not queued.
- load:
  - Validity in 24h: tens <= 2, units <= 9, value <= 23.
  - Validity in 12h: value 01..12.
  - BCD digits > 9 are invalid in both modes.
  - 12h to internal conversion: 12 AM -> 0, 12 PM -> 12, n AM -> n, n PM -> n+12.
  - Valid load: h updates and load_err = 0.
  - Invalid load: h holds and load_err pulses 1 for exactly one cycle.
  - Load never produces day_carry.
- Adjust:
  - adj_up alone: h = (h+1) mod 24.
  - adj_down alone: h = (h == 0) ? 23 : h-1.
  - Both asserted: no change.
  - Adjust wraps silently; day_carry stays 0.
- enable (with no load or adjust): h = (h+1) mod 24. day_carry = 1 for one cycle only on the 23->0 transition, otherwise 0.
- day_carry and load_err are 0 in every cycle not described above, including while enable is held high across non-wrapping hours.
- Reset mid-operation: takes effect immediately. Pending pulses are cleared and any load in that cycle is discarded.
- No illegal h is reachable. If h > 23 is somehow found (SEU), the next edge forces h = 0 with no day_carry.

Test Plan:
- Reset with RESET_HOUR=0 and 24h mode -> tens=0, units=0, pm=0. Apply 24 enable ticks -> sequence 00..23 then 00; day_carry is high exactly once, on the 23->00 edge.
- 12h mode from h=0, 13 ticks -> displays 12 AM, 01 AM .. 11 AM, 12 PM, 01 PM. pm rises at 12 PM.
- In 12h mode, load 11 PM then 1 tick -> 12 AM with day_carry=1. Switch to 24h -> 00 the next cycle.
- Invalid loads: 24h 2/4; 12h 0/0; 12h 1/3; digit units=10 -> each gives a load_err pulse with h unchanged. Valid 24h load 1/9 -> 19 with load_err=0.
- At h=0, adj_down -> 23 with day_carry=0. adj_up and adj_down together -> hold. adj_up together with enable -> advances by 1 only.
- load together with enable at h=23 -> load wins with no day_carry. Async reset asserted mid-pulse -> all outputs take reset values before the next edge.

Source files
------------

// File: rtl/hours_counter_cfg.sv
// BCD hours counter with runtime 12/24h display, validated load, set-mode adjust
// and a registered day-carry pulse on the tick-driven 23->0 wrap.
module hours_counter_cfg #(
  parameter int unsigned RESET_HOUR = 0,
  parameter bit          ENABLE_12H = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       mode_12h,
  input  logic       adj_up,
  input  logic       adj_down,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_units,
  input  logic       load_pm,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       pm,
  output logic       day_carry,
  output logic       load_err
);

  if (RESET_HOUR > 23) begin : g_bad_reset_hour
    $error("hours_counter_cfg: RESET_HOUR must be in 0..23");
  end

  localparam logic [4:0] RST_H     = 5'(RESET_HOUR);
  localparam logic [3:0] RST_TENS  = 4'(RESET_HOUR / 10);
  localparam logic [3:0] RST_UNITS = 4'(RESET_HOUR % 10);
  localparam logic       RST_PM    = (RESET_HOUR >= 12);

  logic [4:0] h, h_next;
  logic       dc_next, le_next;
  logic       m12;
  logic [7:0] load_val;
  logic       digits_ok, load_ok;
  logic [4:0] load_h;
  logic [3:0] tens_next, units_next;

  function automatic logic [7:0] to_bcd(input logic [4:0] v);
    logic [4:0] t;
    logic [4:0] u;
    if (v >= 5'd20)      t = 5'd2;
    else if (v >= 5'd10) t = 5'd1;
    else                 t = 5'd0;
    u = v - 5'(t * 5'd10);
    return {t[3:0], u[3:0]};
  endfunction

  assign m12 = mode_12h & ENABLE_12H;

  // 8 bits: two unchecked nibbles can reach 165 before validation rejects them.
  assign load_val  = 8'(load_tens) * 8'd10 + 8'(load_units);
  assign digits_ok = (load_tens <= 4'd9) && (load_units <= 4'd9);

  always_comb begin
    load_ok = 1'b0;
    load_h  = 5'd0;
    if (m12) begin
      load_ok = digits_ok && (load_val >= 8'd1) && (load_val <= 8'd12);
      load_h  = ((load_val == 8'd12) ? 5'd0 : load_val[4:0]) + (load_pm ? 5'd12 : 5'd0);
    end else begin
      load_ok = digits_ok && (load_val <= 8'd23);
      load_h  = load_val[4:0];
    end
  end

  always_comb begin
    h_next  = h;
    dc_next = 1'b0;
    le_next = 1'b0;
    if (h > 5'd23) begin
      h_next = 5'd0;
    end else if (load) begin
      if (load_ok) h_next  = load_h;
      else         le_next = 1'b1;
    end else if (adj_up || adj_down) begin
      if (adj_up && !adj_down)      h_next = (h == 5'd23) ? 5'd0 : h + 5'd1;
      else if (adj_down && !adj_up) h_next = (h == 5'd0) ? 5'd23 : h - 5'd1;
    end else if (enable) begin
      if (h == 5'd23) begin
        h_next  = 5'd0;
        dc_next = 1'b1;
      end else begin
        h_next = h + 5'd1;
      end
    end
  end

  // Display is encoded from the next hour so outputs track h with no extra cycle.
  always_comb begin
    logic [4:0] d;
    d = h_next;
    if (m12) begin
      if (h_next == 5'd0 || h_next == 5'd12) d = 5'd12;
      else if (h_next > 5'd12)               d = h_next - 5'd12;
    end
    {tens_next, units_next} = to_bcd(d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h         <= RST_H;
      tens      <= RST_TENS;
      units     <= RST_UNITS;
      pm        <= RST_PM;
      day_carry <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      h         <= h_next;
      tens      <= tens_next;
      units     <= units_next;
      pm        <= (h_next >= 5'd12);
      day_carry <= dc_next;
      load_err  <= le_next;
    end
  end

endmodule

// File: tb/tb_hours_counter_cfg.sv
// Directed self-checking bench for hours_counter_cfg (RESET_HOUR=0, ENABLE_12H=1).
module tb_hours_counter_cfg;

  logic       clk = 1'b0;
  logic       reset, enable, mode_12h, adj_up, adj_down, load, load_pm;
  logic [3:0] load_tens, load_units;
  logic [3:0] tens, units;
  logic       pm, day_carry, load_err;

  int n_chk  = 0;
  int n_fail = 0;

  hours_counter_cfg #(.RESET_HOUR(0), .ENABLE_12H(1'b1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode_12h(mode_12h),
    .adj_up(adj_up), .adj_down(adj_down), .load(load),
    .load_tens(load_tens), .load_units(load_units), .load_pm(load_pm),
    .tens(tens), .units(units), .pm(pm), .day_carry(day_carry), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // disp is the displayed two-digit value
  task automatic chk_out(input string tag, input int disp, input int p, input int dc, input int le);
    chk({tag, ".tens"}, 32'(tens), 32'(disp / 10));
    chk({tag, ".units"}, 32'(units), 32'(disp % 10));
    chk({tag, ".pm"}, 32'(pm), 32'(p));
    chk({tag, ".day_carry"}, 32'(day_carry), 32'(dc));
    chk({tag, ".load_err"}, 32'(load_err), 32'(le));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int t, input int u, input int p);
    load = 1'b1; load_tens = 4'(t); load_units = 4'(u); load_pm = p[0];
    tick();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mode_12h = 1'b0; adj_up = 1'b0; adj_down = 1'b0;
    load = 1'b0; load_tens = 4'd0; load_units = 4'd0; load_pm = 1'b0;
    #12;
    chk_out("reset", 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 24h: full day of ticks, carry only on 23->00
    enable = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      chk_out($sformatf("tick24_%0d", i), i % 24, ((i % 24) >= 12) ? 1 : 0, (i == 24) ? 1 : 0, 0);
    end
    enable = 1'b0;

    // 12h from h=0
    mode_12h = 1'b1;
    tick();
    chk_out("m12_h0", 12, 0, 0, 0);
    enable = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      chk_out($sformatf("tick12_%0d", k), (k % 12 == 0) ? 12 : k % 12, (k >= 12) ? 1 : 0, 0, 0);
    end
    enable = 1'b0;

    // 11 PM, then tick -> 12 AM with carry, then 24h shows 00
    do_load(1, 1, 1);
    chk_out("load_11pm", 11, 1, 0, 0);
    enable = 1'b1; tick(); enable = 1'b0;
    chk_out("wrap_12am", 12, 0, 1, 0);
    mode_12h = 1'b0;
    tick();
    chk_out("to_24h", 0, 0, 0, 0);

    // invalid loads hold h and pulse load_err once
    do_load(2, 4, 0);
    chk_out("bad24_2_4", 0, 0, 0, 1);
    tick();
    chk_out("bad24_clear", 0, 0, 0, 0);
    mode_12h = 1'b1;
    do_load(0, 0, 0);
    chk_out("bad12_0_0", 12, 0, 0, 1);
    do_load(1, 3, 1);
    chk_out("bad12_1_3", 12, 0, 0, 1);
    mode_12h = 1'b0;
    do_load(0, 10, 0);
    chk_out("bad_digit", 0, 0, 0, 1);
    do_load(1, 9, 0);
    chk_out("load_19", 19, 1, 0, 0);

    // adjust
    do_load(0, 0, 0);
    chk_out("load_00", 0, 0, 0, 0);
    adj_down = 1'b1; tick();
    chk_out("adj_down_wrap", 23, 1, 0, 0);
    adj_up = 1'b1; tick();
    chk_out("adj_both", 23, 1, 0, 0);
    adj_down = 1'b0; enable = 1'b1; tick();
    chk_out("adj_up_en_wrap", 0, 0, 0, 0);
    tick();
    chk_out("adj_up_en", 1, 0, 0, 0);
    adj_up = 1'b0; enable = 1'b0;

    // load beats enable at 23
    do_load(2, 3, 0);
    chk_out("load_23", 23, 1, 0, 0);
    enable = 1'b1;
    do_load(0, 5, 0);
    chk_out("load_vs_en", 5, 0, 0, 0);
    tick();
    chk_out("en_held", 6, 0, 0, 0);
    enable = 1'b0;

    // async reset mid-pulse clears everything before the next edge
    do_load(2, 3, 0);
    enable = 1'b1; tick(); enable = 1'b0;
    chk_out("pre_reset_dc", 0, 0, 1, 0);
    do_load(1, 7, 0);
    #2 reset = 1'b1;
    #1;
    chk_out("async_reset", 0, 0, 0, 0);
    load = 1'b1; load_tens = 4'd1; load_units = 4'd5;
    tick();
    chk_out("load_in_reset", 0, 0, 0, 0);
    load = 1'b0;
    reset = 1'b0;
    tick();
    chk_out("post_reset", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
